// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache set: request mode encoding,
// per-line metadata record and a log2 helper for derived widths.
package cache_pkg;

  // Mode is {comp, write}
  localparam logic [1:0] ACC_RD = 2'b00;
  localparam logic [1:0] ACC_WR = 2'b01;
  localparam logic [1:0] CMP_RD = 2'b10;
  localparam logic [1:0] CMP_WR = 2'b11;

  // Tags narrower than this are stored zero-extended.
  localparam int LINE_TAG_W = 16;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [LINE_TAG_W-1:0] tag;
  } line_t;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cache_lru_age.sv
// Per-set LRU ages (a permutation of 0..WAYS-1) with touch update and
// victim selection: lowest invalid way, otherwise the oldest way.
//
// age value | meaning
// 0         | most recently used
// WAYS-1    | least recently used, victim when all ways are valid
module cache_lru_age
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  localparam int WAY_W = log2_ceil(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [WAYS-1:0]  valid_vec,
  output logic [WAY_W-1:0] victim
);

  logic [WAYS-1:0][WAY_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (touch) begin
      for (int i = 0; i < WAYS; i++) begin
        if (age_q[i] < age_q[touch_way]) age_d[i] = age_q[i] + 1'b1;
      end
      age_d[touch_way] = '0;
    end
  end

  // Descending scans so the lowest matching index is the one kept.
  always_comb begin
    victim = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (age_q[i] == WAY_W'(WAYS - 1)) victim = WAY_W'(i);
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) victim = WAY_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WAYS; i++) age_q[i] <= WAY_W'(i);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/cache_set_nway.sv
// One set of an N-way set-associative cache: associative or direct access,
// registered one-cycle results, LRU victim reporting on compare misses.
module cache_set_nway
  import cache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int TAG_W  = 5,
  parameter int WORDS  = 4,
  parameter int DATA_W = 16,
  localparam int WORD_W = log2_ceil(WORDS),
  localparam int WAY_W  = log2_ceil(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              comp,
  input  logic              write,
  input  logic [WAY_W-1:0]  way_sel,
  input  logic [WORD_W-1:0] word,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ack,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic              dirty,
  output logic              valid,
  output logic [TAG_W-1:0]  tag_out,
  output logic [DATA_W-1:0] data_out
);

  line_t             lines_q [WAYS];
  line_t             lines_d [WAYS];
  logic [DATA_W-1:0] mem_q   [WAYS][WORDS];
  logic [DATA_W-1:0] mem_d   [WAYS][WORDS];

  logic              ack_q, ack_d, hit_q, hit_d, dirty_q, dirty_d, valid_q, valid_d;
  logic [WAY_W-1:0]  hit_way_q, hit_way_d;
  logic [TAG_W-1:0]  tag_out_q, tag_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic [WAYS-1:0]   valid_vec;
  logic              hit_any;
  logic [WAY_W-1:0]  hit_idx, victim, rep_way;
  logic [1:0]        mode;
  logic              touch;
  line_t             rep_line;

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < WAYS; i++) valid_vec[i] = lines_q[i].valid;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (lines_q[i].valid && lines_q[i].tag == LINE_TAG_W'(tag_in)) begin
        hit_any = 1'b1;
        hit_idx = WAY_W'(i);
      end
    end
  end

  assign mode     = {comp, write};
  assign rep_way  = comp ? (hit_any ? hit_idx : victim) : way_sel;
  assign rep_line = lines_q[rep_way];

  cache_lru_age #(.WAYS(WAYS)) u_lru (
    .clk       (clk),
    .rst       (rst),
    .touch     (touch),
    .touch_way (rep_way),
    .valid_vec (valid_vec),
    .victim    (victim)
  );

  always_comb begin
    lines_d    = lines_q;
    mem_d      = mem_q;
    touch      = 1'b0;
    ack_d      = 1'b0;
    hit_d      = hit_q;
    hit_way_d  = hit_way_q;
    dirty_d    = dirty_q;
    valid_d    = valid_q;
    tag_out_d  = tag_out_q;
    data_out_d = data_out_q;
    if (enable) begin
      ack_d      = 1'b1;
      hit_d      = comp & hit_any;
      hit_way_d  = rep_way;
      dirty_d    = rep_line.dirty;
      valid_d    = rep_line.valid;
      tag_out_d  = rep_line.tag[TAG_W-1:0];
      data_out_d = mem_q[rep_way][word];
      case (mode)
        CMP_RD: touch = hit_any;
        CMP_WR: begin
          if (hit_any) begin
            touch                   = 1'b1;
            mem_d[rep_way][word]    = data_in;
            lines_d[rep_way].dirty  = 1'b1;
            dirty_d                 = 1'b1;
          end
        end
        ACC_WR: begin
          touch                  = 1'b1;
          mem_d[rep_way][word]   = data_in;
          lines_d[rep_way].valid = valid_in;
          lines_d[rep_way].dirty = 1'b0;
          lines_d[rep_way].tag   = LINE_TAG_W'(tag_in);
        end
        default: ;
      endcase
    end
  end

  // Tags keep their contents through reset; only valid/dirty are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= 1'b0;
      hit_q      <= 1'b0;
      hit_way_q  <= '0;
      dirty_q    <= 1'b0;
      valid_q    <= 1'b0;
      tag_out_q  <= '0;
      data_out_q <= '0;
      for (int i = 0; i < WAYS; i++) begin
        lines_q[i].valid <= 1'b0;
        lines_q[i].dirty <= 1'b0;
      end
    end else begin
      ack_q      <= ack_d;
      hit_q      <= hit_d;
      hit_way_q  <= hit_way_d;
      dirty_q    <= dirty_d;
      valid_q    <= valid_d;
      tag_out_q  <= tag_out_d;
      data_out_q <= data_out_d;
      lines_q    <= lines_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) mem_q <= mem_d;
  end

  assign ack      = ack_q;
  assign hit      = hit_q;
  assign hit_way  = hit_way_q;
  assign dirty    = dirty_q;
  assign valid    = valid_q;
  assign tag_out  = tag_out_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_cache_set_nway.sv
// Directed and random requests against a 4-way cache set, checked against
// a line/LRU-list reference model kept in the bench.
module tb_cache_set_nway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, comp = 1'b0, write = 1'b0, valid_in = 1'b0;
  logic [1:0]  way_sel = '0, word = '0;
  logic [4:0]  tag_in = '0;
  logic [15:0] data_in = '0;
  logic        ack, hit, dirty, valid;
  logic [1:0]  hit_way;
  logic [4:0]  tag_out;
  logic [15:0] data_out;

  cache_set_nway #(.WAYS(4), .TAG_W(5), .WORDS(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .comp(comp), .write(write),
    .way_sel(way_sel), .word(word), .tag_in(tag_in), .data_in(data_in),
    .valid_in(valid_in), .ack(ack), .hit(hit), .hit_way(hit_way),
    .dirty(dirty), .valid(valid), .tag_out(tag_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: line contents plus an LRU list ordered MRU first.
  bit          m_valid [4];
  bit          m_dirty [4];
  logic [4:0]  m_tag   [4];
  logic [15:0] m_data  [4][4];
  int          lru_list[$];

  logic        e_ack, e_hit, e_dirty, e_valid;
  logic [1:0]  e_hit_way;
  logic [4:0]  e_tag;
  logic [15:0] e_data;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", nm, obs, exp);
    end
  endtask

  function automatic int lru_pos(input int w);
    for (int i = 0; i < lru_list.size(); i++) if (lru_list[i] == w) return i;
    return -1;
  endfunction

  task automatic model_touch(input int w);
    lru_list.delete(lru_pos(w));
    lru_list.push_front(w);
  endtask

  task automatic model_req(input bit en, input bit r, input bit c, input bit w,
                           input int way, input int wd, input logic [4:0] tg,
                           input logic [15:0] dat, input bit vin);
    bit found;
    int hw, rep;
    if (r) begin
      for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
      lru_list = {0, 1, 2, 3};
      {e_ack, e_hit, e_dirty, e_valid, e_hit_way, e_tag, e_data} = '0;
      return;
    end
    if (!en) begin
      e_ack = 0;
      return;
    end
    found = 0; hw = 0;
    for (int i = 0; i < 4; i++)
      if (!found && m_valid[i] && m_tag[i] == tg) begin found = 1; hw = i; end
    if (!c) rep = way;
    else if (found) rep = hw;
    else begin
      rep = -1;
      for (int i = 0; i < 4; i++) if (rep < 0 && !m_valid[i]) rep = i;
      if (rep < 0) rep = lru_list[lru_list.size() - 1];
    end
    e_ack = 1;
    e_hit = c && found;
    e_hit_way = 2'(rep);
    e_valid = m_valid[rep];
    e_dirty = m_dirty[rep] || (c && w && found);
    e_tag = m_tag[rep];
    e_data = m_data[rep][wd];
    if (c && found) begin
      model_touch(rep);
      if (w) begin m_data[rep][wd] = dat; m_dirty[rep] = 1; end
    end else if (!c && w) begin
      m_data[rep][wd] = dat; m_tag[rep] = tg; m_valid[rep] = vin; m_dirty[rep] = 0;
      model_touch(rep);
    end
  endtask

  task automatic step(input bit en, input bit r, input bit c, input bit w,
                      input int way, input int wd, input logic [4:0] tg,
                      input logic [15:0] dat, input bit vin);
    @(negedge clk);
    enable = en; rst = r; comp = c; write = w; way_sel = 2'(way); word = 2'(wd);
    tag_in = tg; data_in = dat; valid_in = vin;
    model_req(en, r, c, w, way, wd, tg, dat, vin);
    @(posedge clk);
    #1;
    chk("ack", ack, e_ack);
    chk("hit", hit, e_hit);
    chk("hit_way", hit_way, e_hit_way);
    chk("dirty", dirty, e_dirty);
    chk("valid", valid, e_valid);
    chk("tag_out", tag_out, e_tag);
    chk("data_out", data_out, e_data);
  endtask

  initial begin
    step(0, 1, 0, 0, 0, 0, 5'h00, 16'h0, 0);
    // Give every tag and data word a known value, then reset.
    for (int wy = 0; wy < 4; wy++)
      for (int wd = 0; wd < 4; wd++)
        step(1, 0, 0, 1, wy, wd, 5'(wy), 16'($urandom), 0);
    step(1, 1, 0, 0, 0, 0, 5'h00, 16'h0, 0);

    step(1, 0, 1, 0, 0, 0, 5'h03, 16'h0, 0);
    chk("tp_miss_ack", ack, 1);
    chk("tp_miss_hit", hit, 0);
    chk("tp_miss_valid", valid, 0);
    chk("tp_miss_way", hit_way, 0);

    step(1, 0, 0, 1, 1, 2, 5'h0A, 16'hBEEF, 1);
    step(1, 0, 1, 0, 0, 2, 5'h0A, 16'h0, 0);
    chk("tp_hit", hit, 1);
    chk("tp_hit_way", hit_way, 1);
    chk("tp_hit_data", data_out, 16'hBEEF);
    chk("tp_hit_dirty", dirty, 0);

    step(1, 0, 1, 1, 0, 2, 5'h0A, 16'h1234, 0);
    step(1, 0, 1, 0, 0, 2, 5'h0A, 16'h0, 0);
    chk("tp_cw_data", data_out, 16'h1234);
    chk("tp_cw_dirty", dirty, 1);
    step(1, 0, 1, 1, 0, 2, 5'h0B, 16'h5555, 0);
    step(1, 0, 0, 0, 1, 2, 5'h00, 16'h0, 0);
    chk("tp_cwmiss_data", data_out, 16'h1234);
    chk("tp_cwmiss_tag", tag_out, 5'h0A);

    for (int wy = 0; wy < 4; wy++) step(1, 0, 0, 1, wy, 0, 5'(5'h10 + wy), 16'($urandom), 1);
    step(1, 0, 1, 0, 0, 1, 5'h10, 16'h0, 0);
    step(1, 0, 1, 0, 0, 1, 5'h12, 16'h0, 0);
    step(1, 0, 1, 0, 0, 1, 5'h13, 16'h0, 0);
    step(1, 0, 1, 0, 0, 2, 5'h1F, 16'h0, 0);
    chk("tp_victim_way", hit_way, 1);
    chk("tp_victim_tag", tag_out, 5'h11);
    chk("tp_victim_data", data_out, 16'h1234);

    step(1, 1, 1, 1, 0, 0, 5'h10, 16'hAAAA, 0);
    chk("tp_rst_ack", ack, 0);
    for (int i = 0; i < 4; i++) chk("tp_rst_age", dut.u_lru.age_q[i], lru_pos(i));
    for (int wy = 0; wy < 4; wy++) begin
      step(1, 0, 1, 0, 0, 0, 5'(5'h10 + wy), 16'h0, 0);
      chk("tp_rst_miss", hit, 0);
    end

    step(1, 0, 0, 1, 2, 0, 5'h07, 16'hCAFE, 1);
    step(1, 0, 0, 0, 2, 0, 5'h00, 16'h0, 0);
    chk("tp_b2b_data", data_out, 16'hCAFE);
    step(0, 0, 1, 1, 3, 3, 5'h07, 16'h9999, 0);
    chk("tp_idle_ack", ack, 0);

    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 49) == 0,
           1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
           5'($urandom_range(0, 5)), 16'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) chk("end_age", dut.u_lru.age_q[i], lru_pos(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
